// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its execute-stage controller.
// One accepted op stalls the pipeline while a 32-step shift-add multiplier
// or restoring divider runs; the result is presented in the DONE cycle,
// which is also the cycle the stall drops.
module muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;

  // Operand decode for the op waiting in execute.
  logic            in_is_div;
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic            in_div_zero;
  logic            in_div_ovf;
  logic            in_special;
  logic [XLEN-1:0] in_special_res;

  // One iteration of either datapath, plus the result that iteration would finish.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shifted;
  logic              div_ge;
  logic [XLEN-1:0]   hi_step;
  logic [XLEN-1:0]   lo_step;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_s;
  logic [XLEN-1:0]   quotient_s;
  logic [XLEN-1:0]   remainder_s;
  logic [XLEN-1:0]   final_res;

  // Decode signedness, magnitudes and the single-cycle special cases.
  always_comb begin
    in_is_div      = funct3[2];
    in_a_signed    = in_is_div ? ~funct3[0] : (funct3 == 3'd1 || funct3 == 3'd2);
    in_b_signed    = in_is_div ? ~funct3[0] : (funct3 == 3'd1);
    in_a_neg       = in_a_signed & operand_a[XLEN-1];
    in_b_neg       = in_b_signed & operand_b[XLEN-1];
    in_a_mag       = in_a_neg ? -operand_a : operand_a;
    in_b_mag       = in_b_neg ? -operand_b : operand_b;
    in_div_zero    = in_is_div && (operand_b == '0);
    in_div_ovf     = in_is_div && ~funct3[0] && (operand_a == MIN_NEG) && (operand_b == ALL_ONES);
    in_special     = in_div_zero || in_div_ovf;
    in_special_res = '0;
    if (in_div_zero) begin
      in_special_res = funct3[1] ? operand_a : ALL_ONES;
    end else if (in_div_ovf) begin
      in_special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // Single shift-add or restoring-divide step and sign fix-up of the finished value.
  always_comb begin
    mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shifted = {hi_q, lo_q[XLEN-1]};
    div_ge      = div_shifted >= {1'b0, dvs_q};
    if (op_q[2]) begin
      hi_step = div_ge ? (div_shifted[XLEN-1:0] - dvs_q) : div_shifted[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    product     = {hi_step, lo_step};
    product_s   = neg_q ? -product : product;
    quotient_s  = neg_q ? -lo_step : lo_step;
    remainder_s = neg_rem_q ? -hi_step : hi_step;
    if (op_q[2]) begin
      final_res = op_q[1] ? remainder_s : quotient_s;
    end else begin
      final_res = (op_q == 3'd0) ? product_s[XLEN-1:0] : product_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state, datapath load/step and stall/handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d      = funct3;
          neg_d     = in_a_neg ^ in_b_neg;
          neg_rem_d = in_a_neg;
          hi_d      = '0;
          lo_d      = in_is_div ? in_a_mag : in_b_mag;
          dvs_d     = in_is_div ? in_b_mag : in_a_mag;
          cnt_d     = '0;
          if (in_special) begin
            result_d = in_special_res;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hi_d = hi_step;
          lo_d = lo_step;
          if (cnt_q == CW'(ITER - 1)) begin
            cnt_d    = '0;
            result_d = final_res;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall        = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    result       = result_q;
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall shape, results,
// special paths, flush, start handling around DONE and async reset.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic        busy;

  int checks;
  int failures;
  int last_pulse_cycle;

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .funct3       (funct3),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and follow it to its result_valid cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input int exp_lat, input bit hold_start);
    int cyc;
    int stall_cnt;
    bit done;
    funct3    = f;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    cyc       = 0;
    stall_cnt = 0;
    done      = 1'b0;
    while (!done && cyc <= 100) begin
      @(negedge clk);
      if (result_valid) begin
        done = 1'b1;
      end else begin
        if (stall) stall_cnt++;
        stepCycle();
        cyc++;
      end
    end
    last_pulse_cycle = int'($time / 10);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    checkOutput({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    checkOutput({tag, "_result"}, result, exp_res);
    if (!hold_start) start = 1'b0;
    stepCycle();
    start = 1'b0;
  endtask

  initial begin
    int first_pulse;
    bit any_rv;
    checks           = 0;
    failures         = 0;
    last_pulse_cycle = 0;
    rst_n            = 1'b0;
    start            = 1'b0;
    flush            = 1'b0;
    funct3           = 3'd0;
    operand_a        = '0;
    operand_b        = '0;

    // Reset values.
    #3;
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_valid", {31'b0, result_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // Multiplies.
    applyStimulus("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    applyStimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    applyStimulus("mulh_m2_3", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 1'b0);

    // Divides and remainders.
    applyStimulus("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    applyStimulus("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    applyStimulus("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    applyStimulus("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b0);

    // Single-cycle special paths.
    applyStimulus("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    applyStimulus("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    applyStimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);

    // Flush a DIV in its tenth cycle; nothing completes and the old result stays.
    $display("[TB] flush during DIV");
    funct3    = 3'd4;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start     = 1'b1;
    any_rv    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid) any_rv = 1'b1;
      stepCycle();
    end
    flush = 1'b1;
    @(negedge clk);
    if (result_valid) any_rv = 1'b1;
    checkOutput("flush_stall_c10", {31'b0, stall}, 32'd1);
    stepCycle();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    if (result_valid) any_rv = 1'b1;
    checkOutput("flush_busy_c11", {31'b0, busy}, 32'd0);
    checkOutput("flush_stall_c11", {31'b0, stall}, 32'd0);
    checkOutput("flush_no_valid", {31'b0, any_rv}, 32'd0);
    checkOutput("flush_result_held", result, 32'h8000_0000);
    stepCycle();
    applyStimulus("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);

    // Start held through DONE must not launch a second op.
    applyStimulus("mul_hold", 3'd0, 32'd6, 32'd7, 32'd42, 33, 1'b1);
    @(negedge clk);
    checkOutput("hold_busy_c34", {31'b0, busy}, 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("hold_busy_c35", {31'b0, busy}, 32'd0);
    checkOutput("hold_valid_c35", {31'b0, result_valid}, 32'd0);
    stepCycle();

    // Back-to-back MULs, start low only in the DONE cycle.
    applyStimulus("mul_b2b_1", 3'd0, 32'd3, 32'd5, 32'd15, 33, 1'b0);
    first_pulse = last_pulse_cycle;
    applyStimulus("mul_b2b_2", 3'd0, 32'd1000, 32'd1000, 32'h000F_4240, 33, 1'b0);
    checkOutput("b2b_pulse_gap", 32'(last_pulse_cycle - first_pulse), 32'd34);

    // Asynchronous reset in the middle of an op.
    $display("[TB] async reset during BUSY");
    funct3    = 3'd0;
    operand_a = 32'd9;
    operand_b = 32'd9;
    start     = 1'b1;
    for (int i = 0; i < 5; i++) stepCycle();
    @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("async_rst_valid", {31'b0, result_valid}, 32'd0);
    checkOutput("async_rst_result", result, 32'd0);
    #1;
    rst_n = 1'b1;
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit plus the controller that runs it from the execute stage.
- Accepts one M-extension op, then holds the pipeline with a stall while a 32-step shift-add multiplier or restoring divider runs.
- Returns the 32-bit result in the cycle the stall drops, so the held instruction leaves execute carrying that result.
- Operands arrive already forwarded (post-forwarding left/right operands).

Parameters:
- XLEN, 32, operand and result width
- ITER, 32, iteration cycles for the normal path; equals XLEN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  execute stage holds a valid M-extension op (level)
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  in  XLEN  rs1 value after forwarding
- operand_b  in  XLEN  rs2 value after forwarding
- flush  in  1  kill the in-flight op (branch taken / pipeline flush)
- stall  out  1  freeze PC, IF/ID, ID/EX
- result_valid  out  1  result valid this cycle
- result  out  XLEN  op result
- busy  out  1  FSM not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE, stall=0, result_valid=0, result=0, busy=0, all internal accumulators/counters=0.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on start && !flush.
  - Capture operands as magnitudes, sign flags per funct3, and funct3.
  - Iteration counter := 0.
- IDLE -> DONE directly (1-cycle special path) on start && !flush for:
  - DIV/DIVU/REM/REMU with operand_b==0
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF
- BUSY: one iteration per cycle. Counter increments; at counter==ITER-1, go to DONE next edge.
- DONE: result_valid=1 for exactly one cycle, then IDLE. start is ignored in DONE, because it is still the same instruction.
- Any state with flush=1 -> IDLE next edge; no result_valid. flush has priority over start.
- stall = (state==IDLE && start && !flush) || state==BUSY. stall=0 in DONE.
- Normal latency: start seen in cycle 0; BUSY cycles 1..32; result_valid in cycle 33. stall is high cycles 0..32.
- Special-path latency: result_valid in cycle 1; stall high only in cycle 0.
- busy = (state != IDLE).
- Multiply: unsigned 32x32 -> 64-bit shift-add on magnitudes.
  - Negate the 64-bit product if the operand signs differ.
  - Signedness: MULH both signed, MULHSU a signed / b unsigned, MULHU both unsigned.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring division on magnitudes, 1 quotient bit per cycle.
  - Signed ops: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = operand_a.
- Signed overflow (-2^31 / -1): quotient = 0x80000000; remainder = 0.
- result holds its value after DONE until the next DONE or reset. Only result_valid qualifies it.
- Reset mid-operation: immediate return to the reset values; the op is lost.
- Simultaneous flush in DONE: result_valid is still 1 that cycle (already computed). The consumer must qualify it with its own flush.

Test Plan:
- Reset: rst_n=0 asserted asynchronously during BUSY -> outputs and state return to the reset values immediately, with no wait for a clock edge; stall=0 with start=0.
- MUL a=7 b=-3 -> stall high cycles 0..32; cycle 33 result_valid=1, result=0xFFFFFFEB. MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE.
- DIV a=-7 b=2 -> quotient 0xFFFFFFFD. REM a=-7 b=2 -> 0xFFFFFFFF. DIVU a=100 b=7 -> 14. REMU -> 2.
- Special paths, each with result_valid in cycle 1:
  - DIVU a=5 b=0 -> 0xFFFFFFFF.
  - REM a=5 b=0 -> 5.
  - DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, result_valid never asserts, stall drops at cycle 11. A new MULHSU started at cycle 12 completes correctly (a=-1, b=2 -> 0xFFFFFFFF).
- start held high through DONE -> no second operation. Back-to-back MULs with start continuous except through DONE -> two result_valid pulses 34 cycles apart.
